// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and width defaults for the memory port arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, ISS_F, ISS_D} state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between fetch and data with starvation-bounded data priority
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_dm
);
  state_t state, state_nx;
  logic [1:0] starve, starve_nx;
  logic wr_q;
  logic el_f, el_d, iss_f, iss_d, starved;
  // A requester acked this cycle is still counted outstanding, so it cannot re-issue until the next cycle
  assign if_ack = (state == ISS_F) & ~rst;
  assign dm_ack = (state == ISS_D) & ~rst;
  assign el_f = if_req & ~if_ack;
  assign el_d = dm_req & ~dm_ack;
  assign starved = starve == 2'(STARVE_MAX);
  assign iss_d = ~rst & el_d & ~(el_f & starved);
  assign iss_f = ~rst & el_f & ~iss_d;
  assign mem_en = iss_f | iss_d;
  assign mem_we = iss_d & dm_we;
  assign mem_addr = iss_d ? dm_addr : iss_f ? if_addr : '0;
  assign mem_wdata = iss_d ? dm_wdata : '0;
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign dm_rdata = (dm_ack & ~wr_q) ? mem_rdata : '0;
  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;
  // Next last-issue state and starvation count from this cycle's grant
  always_comb begin
    state_nx = iss_f ? ISS_F : iss_d ? ISS_D : IDLE;
    starve_nx = (~if_req | iss_f) ? 2'd0 : (iss_d & ~starved) ? starve + 2'd1 : starve;
  end
  // State, starvation count and write flag of the access being acked next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve <= '0;
      wr_q <= 1'b0;
    end else begin
      state <= state_nx;
      starve <= starve_nx;
      wr_q <= iss_d & dm_we;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a cycle-level reference model
module tb_mem_port_arbiter;
  localparam int SM = 2;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [7:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic if_ack, dm_ack, mem_en, mem_we, stall_if, stall_dm;
  logic [7:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic clr = 1;
  logic [7:0] mem [256];
  logic [7:0] rd_q = 0;
  logic [7:0] ref_mem [256];
  int n_cmp = 0, n_err = 0;
  int m_last = 0, m_starve = 0;
  logic [7:0] m_pf = 0, m_pd = 0;
  logic m_e_f = 0, m_e_d = 0;
  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );
  always #5 clk = ~clk;
  assign mem_rdata = rd_q;
  // Single-port synchronous memory seen by the arbiter
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    else if (mem_en) rd_q <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic ir, input logic [7:0] ia, input logic dr,
                      input logic dw, input logic [7:0] da, input logic [7:0] dd);
    int iss;
    logic ea_f, ea_d;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    #1;
    ea_f = !r && m_last == 1;
    ea_d = !r && m_last == 2;
    iss = 0;
    if (!r) begin
      if (ir && !ea_f && dr && !ea_d) iss = (m_starve == SM) ? 1 : 2;
      else if (ir && !ea_f) iss = 1;
      else if (dr && !ea_d) iss = 2;
    end
    chk("if_ack", if_ack, ea_f);
    chk("dm_ack", dm_ack, ea_d);
    chk("if_rdata", if_rdata, ea_f ? m_pf : 8'h00);
    chk("dm_rdata", dm_rdata, ea_d ? m_pd : 8'h00);
    chk("mem_en", mem_en, iss != 0);
    chk("mem_we", mem_we, iss == 2 && dw);
    chk("mem_addr", mem_addr, iss == 1 ? ia : iss == 2 ? da : 8'h00);
    chk("mem_wdata", mem_wdata, iss == 2 ? dd : 8'h00);
    chk("stall_if", stall_if, ir && !ea_f);
    chk("stall_dm", stall_dm, dr && !ea_d);
    if (iss == 1) m_pf = ref_mem[ia];
    if (iss == 2) begin
      m_pd = dw ? 8'h00 : ref_mem[da];
      if (dw) ref_mem[da] = dd;
    end
    m_starve = (r || !ir || iss == 1) ? 0 : (iss == 2) ? ((m_starve < SM) ? m_starve + 1 : SM) : m_starve;
    m_last = iss;
    m_e_f = ea_f;
    m_e_d = ea_d;
  endtask
  initial begin
    logic ir, dr, dw, r;
    logic [7:0] ia, da, dd;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h10, 0, 0, 0, 0);
    chk("rst_stall_if", stall_if, 1);
    clr = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h10, 8'hA5);
    step(0, 0, 0, 1, 1, 8'h10, 8'hA5);
    step(0, 1, 8'h10, 0, 0, 0, 0);
    chk("fetch_addr", mem_addr, 8'h10);
    step(0, 1, 8'h10, 0, 0, 0, 0);
    chk("fetch_data", if_rdata, 8'hA5);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h20, 1, 0, 8'h80, 0);
    chk("sim_data_first", mem_addr, 8'h80);
    step(0, 1, 8'h20, 1, 0, 8'h80, 0);
    chk("sim_fetch_next", mem_addr, 8'h20);
    step(0, 1, 8'h20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h90, 8'h33);
    step(0, 0, 0, 1, 1, 8'h90, 8'h33);
    step(0, 0, 0, 1, 0, 8'h90, 0);
    step(0, 0, 0, 1, 0, 8'h90, 0);
    chk("raw_data", dm_rdata, 8'h33);
    step(0, 0, 0, 0, 0, 0, 0);
    da = 8'h40;
    for (int k = 0; k < 36; k++) begin
      step(0, 1, 8'h60, 1, 0, da, 0);
      if (m_e_d) da = (da == 8'h4F) ? 8'h40 : da + 8'h01;
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h05, 0, 0, 0, 0);
    step(1, 1, 8'h05, 0, 0, 0, 0);
    chk("rst_drop_ack", if_ack, 0);
    step(1, 1, 8'h05, 0, 0, 0, 0);
    step(0, 1, 8'h05, 0, 0, 0, 0);
    chk("reissue", mem_en, 1);
    step(0, 1, 8'h05, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0, 0);
    chk("idle_en", mem_en, 0);
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dd = 0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 49) == 0;
      step(r, ir, ia, dr, dw, da, dd);
      if (!ir || m_e_f) begin
        ir = $urandom_range(0, 2) != 0;
        ia = 8'($urandom_range(0, 15));
      end
      if (!dr || m_e_d) begin
        dr = $urandom_range(0, 2) != 0;
        dw = $urandom_range(0, 1) == 1;
        da = 8'($urandom_range(0, 15));
        dd = 8'($urandom);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
